// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: FSM states, frame header and word geometry.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN0  = 3'd0,
    ST_LEN1  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned LEN_W          = 8 * HDR_BYTES;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

  // States in which the host link may hand over a byte
  function automatic logic is_rx_state(input state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA);
  endfunction

  // States in which an idle host counts toward the timeout
  function automatic logic is_timed_state(input state_t s);
    return (s == ST_LEN1) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/boot_loader_word_asm.sv
// Little-endian word assembly: places each accepted byte in lane byte_cnt and flags the 4th byte.
module boot_word_asm
  import boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic [7:0]        i_byte,
  output logic [WORD_W-1:0] o_word_c,
  output logic              o_word_ready_c
);

  logic [LANE_W-1:0] r_byte_cnt;
  logic [WORD_W-1:0] r_word;

  // Word as it will look once the incoming byte lands in its lane
  always_comb begin
    o_word_c = r_word;
    case (r_byte_cnt)
      2'd0:    o_word_c[7:0]   = i_byte;
      2'd1:    o_word_c[15:8]  = i_byte;
      2'd2:    o_word_c[23:16] = i_byte;
      default: o_word_c[31:24] = i_byte;
    endcase
  end

  assign o_word_ready_c = i_accept && (r_byte_cnt == LANE_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else if (i_clear) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else if (i_accept) begin
      r_byte_cnt <= r_byte_cnt + LANE_W'(1);
      r_word     <= o_word_c;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Program-load stage: parses a length-prefixed byte stream into instruction-memory writes
// and holds the core in reset until the image is complete.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CMP_W = LEN_W + 1;
  localparam logic [CMP_W-1:0] MAX_WORDS = CMP_W'(64'd1 << ADDR_W);

  state_t              r_state;
  state_t              w_next;
  logic [LEN_W-1:0]    r_n;
  logic [LEN_W-1:0]    w_len;
  logic [ADDR_W-1:0]   r_word_idx;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [WORD_W-1:0]   r_imem_wdata;
  logic                r_core_rst;
  logic                r_done;
  logic                r_error;

  logic                w_xfer;
  logic                w_accept;
  logic                w_tmo_expired;
  logic                w_last_word;
  logic [WORD_W-1:0]   w_word;
  logic                w_word_ready;

  assign byte_ready = is_rx_state(r_state);
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign core_rst   = r_core_rst;
  assign done       = r_done;
  assign error      = r_error;

  // A restart drops any byte offered in the same cycle
  assign w_xfer   = byte_valid && byte_ready && !restart;
  assign w_accept = w_xfer && (r_state == ST_DATA);

  boot_word_asm u_word_asm (
    .clk            (clk),
    .rst            (rst),
    .i_clear        (restart),
    .i_accept       (w_accept),
    .i_byte         (byte_data),
    .o_word_c       (w_word),
    .o_word_ready_c (w_word_ready)
  );

  // Next-state logic
  always_comb begin
    w_next        = r_state;
    w_len         = {byte_data, r_n[7:0]};
    w_tmo_expired = is_timed_state(r_state) && !w_xfer && (r_tmo == TMO_W'(TIMEOUT - 1));
    w_last_word   = (CMP_W'(r_word_idx) + CMP_W'(1)) == CMP_W'(r_n);
    if (restart) begin
      w_next = ST_LEN0;
    end else begin
      case (r_state)
        ST_LEN0: begin
          if (w_xfer) w_next = ST_LEN1;
        end
        ST_LEN1: begin
          if (w_xfer) begin
            if (w_len == '0)                     w_next = ST_DONE;
            else if (CMP_W'(w_len) > MAX_WORDS)  w_next = ST_ERR;
            else                                 w_next = ST_DATA;
          end else if (w_tmo_expired) begin
            w_next = ST_ERR;
          end
        end
        ST_DATA: begin
          if (w_word_ready)       w_next = ST_WRITE;
          else if (w_tmo_expired) w_next = ST_ERR;
        end
        ST_WRITE: begin
          w_next = w_last_word ? ST_DONE : ST_DATA;
        end
        ST_DONE: w_next = ST_DONE;
        ST_ERR:  w_next = ST_ERR;
        default: w_next = ST_LEN0;
      endcase
    end
  end

  // State register and Moore outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_LEN0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_core_rst   <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_imem_we  <= (w_next == ST_WRITE);
      r_core_rst <= (w_next != ST_DONE);
      r_done     <= (w_next == ST_DONE);
      r_error    <= (w_next == ST_ERR);
      if (w_next == ST_WRITE) begin
        r_imem_addr  <= r_word_idx;
        r_imem_wdata <= w_word;
      end
    end
  end

  // Word count, write address and idle timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n        <= '0;
      r_word_idx <= '0;
      r_tmo      <= '0;
    end else if (restart) begin
      r_n        <= '0;
      r_word_idx <= '0;
      r_tmo      <= '0;
    end else begin
      if (w_xfer && r_state == ST_LEN0) r_n[7:0]  <= byte_data;
      if (w_xfer && r_state == ST_LEN1) r_n[15:8] <= byte_data;
      if (r_state == ST_WRITE && w_next == ST_DATA) r_word_idx <= r_word_idx + ADDR_W'(1);
      if (w_xfer || !is_timed_state(r_state)) r_tmo <= '0;
      else                                    r_tmo <= r_tmo + TMO_W'(1);
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: random frames, expected writes queued at stimulus time.
module tb_boot_loader;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              restart = 1'b0;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              error;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .restart    (restart),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin : monitor
    wr_t e;
    if (!rst && imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(e.addr));
        check("write_data", imem_wdata, e.data);
      end
    end
  end

  // All driving happens 1 time unit after a rising edge
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    bit ok;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      ok = byte_ready;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_byte_stall: got byte_ready 0 for 64 cycles expected acceptance");
    end
  endtask

  task automatic send_header(input int n, input int max_gap);
    send_byte(8'(n), max_gap);
    send_byte(8'(n >> 8), max_gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) send_byte(8'(w >> (8 * i)), max_gap);
  endtask

  // Reference model: legal N yields N sequential writes from address 0
  task automatic send_frame_rand(input int n, input int max_gap);
    logic [31:0] w;
    send_header(n, max_gap);
    if (n > 0 && n <= int'(DEPTH)) begin
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        exp_q.push_back('{addr: ADDR_W'(i), data: w});
        send_word(w, max_gap);
      end
    end
  endtask

  task automatic do_restart(input bit with_byte);
    restart    = 1'b1;
    byte_valid = with_byte;
    byte_data  = 8'h01;
    @(posedge clk); #1;
    restart    = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic check_status(input string name, input bit exp_done, input bit exp_err);
    check({name, "_done"}, 32'(done), 32'(exp_done));
    check({name, "_error"}, 32'(error), 32'(exp_err));
    check({name, "_core_rst"}, 32'(core_rst), 32'(!exp_done));
    check({name, "_byte_ready"}, 32'(byte_ready), 32'(!(exp_done || exp_err)));
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (!done && !error && cyc < 2000) begin @(posedge clk); #1; cyc++; end
    check_status(name, 1'b1, 1'b0);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : stimulus
    int cyc;
    logic [31:0] w0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check_status("rst", 1'b0, 1'b0);
    rst = 1'b0;

    // Two-word image with fixed contents and exact done latency
    exp_q.push_back('{addr: ADDR_W'(0), data: 32'h00000513});
    exp_q.push_back('{addr: ADDR_W'(1), data: 32'h00100093});
    send_header(2, 0);
    send_word(32'h00000513, 0);
    send_word(32'h00100093, 0);
    check("t1_we_in_write", 32'(imem_we), 32'd1);
    check("t1_done_in_write", 32'(done), 32'd0);
    check("t1_core_rst_in_write", 32'(core_rst), 32'd1);
    @(posedge clk); #1;
    check_status("t1_after_write", 1'b1, 1'b0);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Empty image goes straight to DONE
    do_restart(1'b0);
    check_status("restart_from_done", 1'b0, 1'b0);
    send_header(0, 0);
    check_status("t2_empty", 1'b1, 1'b0);

    // Oversize image is rejected
    do_restart(1'b0);
    send_header(DEPTH + 1, 0);
    check_status("t3_oversize", 1'b0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    check_status("t3_held", 1'b0, 1'b1);

    // Exactly full memory is legal
    do_restart(1'b0);
    send_frame_rand(DEPTH, 0);
    wait_done("t3_full");

    // Idle timeout after a partial word
    do_restart(1'b0);
    send_header(1, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    cyc = 0;
    while (!error && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("t4_timeout_cycles", 32'(cyc), 32'(TIMEOUT));
    check_status("t4_timeout", 1'b0, 1'b1);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Three words with random valid gaps, then several random frames
    do_restart(1'b0);
    send_frame_rand(3, 3);
    wait_done("t5_n3");
    for (int k = 0; k < 4; k++) begin
      do_restart(1'b0);
      send_frame_rand(int'($urandom_range(6, 1)), 2);
      wait_done("t5_rand");
    end

    // Restart with a simultaneous byte: in DONE and in LEN0, byte must be dropped
    do_restart(1'b1);
    check_status("t6_restart_done", 1'b0, 1'b0);
    do_restart(1'b1);
    check_status("t6_restart_len0", 1'b0, 1'b0);
    send_frame_rand(2, 1);
    wait_done("t6_reload");

    // Asynchronous reset mid-DATA
    do_restart(1'b0);
    w0 = $urandom;
    exp_q.push_back('{addr: ADDR_W'(0), data: w0});
    send_header(2, 0);
    send_word(w0, 0);
    send_byte(8'h5A, 0);
    #2;
    rst = 1'b1;
    #1;
    check("t7_rst_imem_we", 32'(imem_we), 32'd0);
    check("t7_rst_imem_addr", 32'(imem_addr), 32'd0);
    check("t7_rst_imem_wdata", imem_wdata, 32'd0);
    check_status("t7_rst", 1'b0, 1'b0);
    check("t7_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame_rand(3, 1);
    wait_done("t7_reload");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
